// File: rtl/upper_layer_4_4_merge.sv
// upper_layer_4_4_merge
// Merges two ascending runs (A and B, RUN_LEN elements each) into one
// ascending run of 2*RUN_LEN elements. Stable: on equal values A goes first.
// Optional build macro ORDER_CHECK_EN adds a sticky order_err output that
// flags out-of-order input or output elements within a run.
//
// Handshake: every stream (a_*, b_*, out_*) transfers a beat on a rising
// clk edge where valid && ready are both high; a producer holds valid and
// data stable until the transfer, and ready never depends on valid.

module upper_layer_4_4_merge #(
    parameter int DATA_WIDTH = 8,
    parameter int RUN_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy
`ifdef ORDER_CHECK_EN
    ,
    output logic                  order_err
`endif
);

    localparam int CW = $clog2(2 * RUN_LEN) + 1;
    localparam logic [CW-1:0] RUN_CNT   = CW'(RUN_LEN);
    localparam logic [CW-1:0] TOTAL_CNT = CW'(2 * RUN_LEN);

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    state_t                state, state_nxt;

    logic [DATA_WIDTH-1:0] a_head, b_head;
    logic                  a_hv, b_hv;
    logic [CW-1:0]         a_cnt, b_cnt, o_cnt;
    logic [CW-1:0]         o_cnt_inc;

    logic                  in_merge;
    logic                  a_acc, b_acc;
    logic                  a_done, b_done;
    logic                  out_free;
    logic                  pick_a, pick_b;
    logic                  last_acc;

    assign in_merge  = (state == MERGE);
    assign a_acc     = a_valid && a_ready;
    assign b_acc     = b_valid && b_ready;
    assign a_done    = (a_cnt == RUN_CNT) && !a_hv;
    assign b_done    = (b_cnt == RUN_CNT) && !b_hv;
    assign out_free  = !out_valid || out_ready;
    assign last_acc  = out_valid && out_ready && out_last;
    assign o_cnt_inc = o_cnt + CW'(1);

    // Head selection: smaller head wins, A wins ties; an exhausted side lets the other drain
    assign pick_a = in_merge && out_free && a_hv && (b_hv ? (a_head <= b_head) : b_done);
    assign pick_b = in_merge && out_free && !pick_a && b_hv && (a_hv ? (b_head < a_head) : a_done);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: IDLE is a one-cycle gap between runs; MERGE ends on the accepted last beat
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = MERGE;
            MERGE:   if (last_acc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: ready only while merging, head empty and run not yet fully accepted
    always_comb begin
        busy    = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (state == MERGE) begin
            busy    = 1'b1;
            a_ready = !a_hv && (a_cnt < RUN_CNT);
            b_ready = !b_hv && (b_cnt < RUN_CNT);
        end
    end

    // Head registers: load on accept, empty when the head is pushed to the output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_head <= '0;
            a_hv   <= 1'b0;
            b_head <= '0;
            b_hv   <= 1'b0;
        end else begin
            if (a_acc) begin
                a_head <= a_data;
                a_hv   <= 1'b1;
            end else if (pick_a) begin
                a_hv   <= 1'b0;
            end
            if (b_acc) begin
                b_head <= b_data;
                b_hv   <= 1'b1;
            end else if (pick_b) begin
                b_hv   <= 1'b0;
            end
        end
    end

    // Run counters: cleared when the last merged beat leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt <= '0;
            b_cnt <= '0;
            o_cnt <= '0;
        end else if (last_acc) begin
            a_cnt <= '0;
            b_cnt <= '0;
            o_cnt <= '0;
        end else begin
            if (a_acc)            a_cnt <= a_cnt + CW'(1);
            if (b_acc)            b_cnt <= b_cnt + CW'(1);
            if (pick_a || pick_b) o_cnt <= o_cnt_inc;
        end
    end

    // Output register: refilled only when empty or being consumed, so it holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (in_merge && out_free) begin
            if (pick_a) begin
                out_valid <= 1'b1;
                out_data  <= a_head;
                out_last  <= (o_cnt_inc == TOTAL_CNT);
            end else if (pick_b) begin
                out_valid <= 1'b1;
                out_data  <= b_head;
                out_last  <= (o_cnt_inc == TOTAL_CNT);
            end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef ORDER_CHECK_EN
    // Sticky order flag: a head still holds the previous accepted value of its side and
    // out_data the previous emitted value, so each only counts once its counter is nonzero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            order_err <= 1'b0;
        end else if ((a_acc && (a_cnt != '0) && (a_data < a_head)) ||
                     (b_acc && (b_cnt != '0) && (b_data < b_head)) ||
                     (pick_a && (o_cnt != '0) && (a_head < out_data)) ||
                     (pick_b && (o_cnt != '0) && (b_head < out_data))) begin
            order_err <= 1'b1;
        end
    end
`endif

endmodule
